// File: rtl/regfile_sequencer.sv
// Control-side sequencer for the 8-entry register file (R1-R4, S1-S4).
// Clears every register after reset, then runs one MOV/ALU/INC/DEC/CLR operation at a time.
module regfile_sequencer #(
  parameter logic [2:0]  FS_DEC      = 3'b000,
  parameter logic [2:0]  FS_INC      = 3'b001,
  parameter logic [2:0]  FS_LOAD     = 3'b010,
  parameter logic [2:0]  FS_CLR      = 3'b011,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [2:0] req_dst,
  input  logic [2:0] req_srca,
  input  logic [2:0] req_srcb,
  output logic [2:0] OutASel,
  output logic [2:0] OutBSel,
  output logic [2:0] FunSel,
  output logic [3:0] RegSel,
  output logic [3:0] ScrSel,
  output logic       ISel,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       done,
  output logic       err,
  output logic       init_busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(ALU_TIMEOUT);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ALU = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4;

  typedef enum logic [1:0] {INIT, IDLE, ALU_WAIT, WRITE} state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       dst_q;
  logic [CNT_W-1:0] cnt_q;

  // {RegSel, ScrSel} with only register idx enabled (R1 is the MSB)
  function automatic logic [7:0] sel_for(input logic [2:0] idx);
    return ~(8'b1000_0000 >> idx);
  endfunction

  function automatic logic [2:0] fun_for(input logic [2:0] op);
    case (op)
      OP_INC:  return FS_INC;
      OP_DEC:  return FS_DEC;
      OP_CLR:  return FS_CLR;
      default: return FS_LOAD;
    endcase
  endfunction

  // Outputs are registered: each edge loads the values for the cycle that follows it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= INIT;
      idx_q     <= 3'd0;
      dst_q     <= 3'd0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      OutASel   <= 3'd0;
      OutBSel   <= 3'd0;
      FunSel    <= FS_LOAD;
      RegSel    <= 4'b1111;
      ScrSel    <= 4'b1111;
      ISel      <= 1'b0;
      alu_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      alu_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state_q)
        INIT: begin
          FunSel            <= FS_CLR;
          {RegSel, ScrSel}  <= sel_for(idx_q);
          idx_q             <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= IDLE;
        end

        IDLE: begin
          init_busy        <= 1'b0;
          req_ready        <= 1'b1;
          {RegSel, ScrSel} <= 8'hFF;
          ISel             <= 1'b0;
          FunSel           <= FS_LOAD;
          if (req_valid && req_ready) begin
            dst_q <= req_dst;
            case (req_op)
              OP_ALU: begin
                state_q   <= ALU_WAIT;
                req_ready <= 1'b0;
                alu_start <= 1'b1;
                OutASel   <= req_srca;
                OutBSel   <= req_srcb;
                cnt_q     <= '0;
              end
              OP_MOV, OP_INC, OP_DEC, OP_CLR: begin
                state_q          <= WRITE;
                req_ready        <= 1'b0;
                OutASel          <= (req_op == OP_MOV) ? req_srca : req_dst;
                FunSel           <= fun_for(req_op);
                {RegSel, ScrSel} <= sel_for(req_dst);
              end
              default: err <= 1'b1;
            endcase
          end
        end

        // The alu_start cycle itself never samples alu_done; done beats timeout on a tie.
        ALU_WAIT: begin
          if (!alu_start) begin
            if (alu_done) begin
              state_q          <= WRITE;
              ISel             <= 1'b1;
              FunSel           <= FS_LOAD;
              {RegSel, ScrSel} <= sel_for(dst_q);
            end else if (cnt_q + CNT_W'(1) == TMO) begin
              state_q   <= IDLE;
              err       <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        WRITE: begin
          state_q          <= IDLE;
          done             <= 1'b1;
          req_ready        <= 1'b1;
          {RegSel, ScrSel} <= 8'hFF;
          ISel             <= 1'b0;
          FunSel           <= FS_LOAD;
        end

        default: state_q <= INIT;
      endcase
    end
  end

endmodule
